// File: rtl/mini_core_accel_mul_int8.sv
// Sequential shift-add multiplier: restarts whenever the operand pair differs from the captured pair.
// Define MINI_CORE_ACCEL_MUL_SIGNED_EN for two's-complement operands (magnitude multiply plus sign fix-up).
module mini_core_accel_mul_int8 #(
  parameter int OPERAND_W = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [OPERAND_W-1:0]     multiplicand,
  input  logic [OPERAND_W-1:0]     multiplier,
  output logic                     done,
  output logic [2*OPERAND_W-1:0]   result
);

  localparam int RES_W = 2 * OPERAND_W;
  localparam int CNT_W = $clog2(OPERAND_W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OPERAND_W-1:0] r_mcand_cap;
  logic [OPERAND_W-1:0] r_mplier_cap;
  logic [OPERAND_W-1:0] r_mag_a;
  logic [OPERAND_W-1:0] r_mag_b;
  logic [RES_W-1:0]     r_acc;
  logic [RES_W-1:0]     r_result;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic                 w_capture;
  logic                 w_last;
  logic [OPERAND_W-1:0] w_mag_a;
  logic [OPERAND_W-1:0] w_mag_b;
  logic [RES_W-1:0]     w_partial;
  logic [RES_W-1:0]     w_acc_nxt;
  logic [RES_W-1:0]     w_product;

`ifdef MINI_CORE_ACCEL_MUL_SIGNED_EN
  logic r_neg;

  // Magnitude of a two's-complement operand; the most negative value maps to 2^(W-1), which still fits unsigned.
  function automatic logic [OPERAND_W-1:0] f_mag(input logic [OPERAND_W-1:0] x);
    return x[OPERAND_W-1] ? ((~x) + OPERAND_W'(1)) : x;
  endfunction

  function automatic logic [RES_W-1:0] f_apply_sign(input logic [RES_W-1:0] p, input logic neg);
    return neg ? ((~p) + RES_W'(1)) : p;
  endfunction

  assign w_mag_a   = f_mag(multiplicand);
  assign w_mag_b   = f_mag(multiplier);
  assign w_product = f_apply_sign(w_acc_nxt, r_neg);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)          r_neg <= 1'b0;
    else if (w_capture) r_neg <= multiplicand[OPERAND_W-1] ^ multiplier[OPERAND_W-1];
  end
`else
  assign w_mag_a   = multiplicand;
  assign w_mag_b   = multiplier;
  assign w_product = w_acc_nxt;
`endif

  assign w_capture = {multiplicand, multiplier} != {r_mcand_cap, r_mplier_cap};
  assign w_last    = (r_cnt == CNT_W'(OPERAND_W - 1));
  assign w_partial = r_mag_b[r_cnt] ? (RES_W'(r_mag_a) << r_cnt) : '0;
  assign w_acc_nxt = r_acc + w_partial;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // An operand change wins over everything, including a BUSY step in flight.
  always_comb begin
    w_state_nxt = r_state;
    if (w_capture) begin
      w_state_nxt = BUSY;
    end else begin
      case (r_state)
        BUSY:    if (w_last) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_mcand_cap  <= '0;
      r_mplier_cap <= '0;
      r_mag_a      <= '0;
      r_mag_b      <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_result     <= '0;
    end else if (w_capture) begin
      r_mcand_cap  <= multiplicand;
      r_mplier_cap <= multiplier;
      r_mag_a      <= w_mag_a;
      r_mag_b      <= w_mag_b;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_product;
        r_done   <= 1'b1;
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule
